// File: rtl/rr_router_merge.sv
// rr_router_merge: N:1 round-robin merge into a DEPTH-entry output FIFO.
// Each cycle one valid input is granted, starting the search at the input
// after the one granted last. Its flit is written into the FIFO, which
// drains through a valid/ready handshake.
// Optional feature macro: RR_MERGE_STATS_EN adds saturating 16-bit
// per-input transfer counters on output grant_cnt.
module rr_router_merge #(
   parameter  int NUM_IN = 5,
   parameter  int WIDTH  = 11,
   parameter  int DEPTH  = 4,
   localparam int GW     = $clog2(NUM_IN),
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_IN*WIDTH-1:0]   in_data,
   input  logic [NUM_IN-1:0]         in_valid,
   output logic [NUM_IN-1:0]         in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [GW-1:0]             grant_id,
   output logic [CW-1:0]             fifo_count
`ifdef RR_MERGE_STATS_EN
   ,
   output logic [NUM_IN*16-1:0]      grant_cnt
`endif
);

   logic [WIDTH-1:0] in_flit [NUM_IN];

   logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] out_data_q, out_data_d;

   logic             can_push;
   logic             grant_vld;
   logic [GW-1:0]    grant_idx;
   logic [WIDTH-1:0] push_data;
   logic             push;
   logic             pop;
   int               arb_idx;

   for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
      assign in_flit[g] = in_data[g*WIDTH +: WIDTH];
   end

   // Round-robin search from rr_ptr; a pop in the same cycle does not make room.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      arb_idx   = 0;
      can_push  = !rst && (count_q < CW'(DEPTH));
      for (int k = 0; k < NUM_IN; k++) begin
         arb_idx = int'(rr_ptr_q) + k;
         if (arb_idx >= NUM_IN) begin
            arb_idx = arb_idx - NUM_IN;
         end
         if (!grant_vld && in_valid[GW'(arb_idx)]) begin
            grant_vld = 1'b1;
            grant_idx = GW'(arb_idx);
         end
      end
      if (!can_push) begin
         grant_vld = 1'b0;
         grant_idx = '0;
      end
   end

   // One-hot grant and grant index outputs.
   always_comb begin
      in_ready = '0;
      if (grant_vld) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   assign grant_id   = grant_idx;
   assign push       = grant_vld;
   assign push_data  = in_flit[grant_idx];
   assign out_valid  = (count_q != '0);
   assign pop        = !rst && out_valid && out_ready;
   assign out_data   = out_data_q;
   assign fifo_count = count_q;

   // Next-state for pointers, occupancy and the registered head flit.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      out_data_d = out_data_q;
      if (push) begin
         rr_ptr_d = (grant_idx == GW'(NUM_IN - 1)) ? '0 : grant_idx + GW'(1);
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // The head only comes from the incoming flit when that flit lands in
      // the slot the read pointer is moving to; otherwise it is already stored.
      // When the FIFO drains, the last flit stays on out_data.
      if (count_d != '0) begin
         if (push && (rd_ptr_d == wr_ptr_q)) begin
            out_data_d = push_data;
         end else begin
            out_data_d = mem_q[rd_ptr_d];
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         out_data_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         out_data_q <= out_data_d;
      end
   end

   // FIFO storage; push is already suppressed during reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

`ifdef RR_MERGE_STATS_EN
   logic [15:0] cnt_q [NUM_IN];

   // Per-input transfer counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_IN; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (push && (cnt_q[grant_idx] != 16'hFFFF)) begin
         cnt_q[grant_idx] <= cnt_q[grant_idx] + 16'd1;
      end
   end

   for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
      assign grant_cnt[g*16 +: 16] = cnt_q[g];
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_rr_router_merge.sv
// Directed bench for rr_router_merge with a reference model and a queue
// scoreboard of accepted flits, compared as they leave the FIFO.
module tb_rr_router_merge;
   localparam int NUM_IN = 5;
   localparam int WIDTH  = 11;
   localparam int DEPTH  = 4;
   localparam int GW     = $clog2(NUM_IN);
   localparam int CW     = $clog2(DEPTH) + 1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_IN*WIDTH-1:0]  in_data;
   logic [NUM_IN-1:0]        in_valid;
   logic [NUM_IN-1:0]        in_ready;
   logic [WIDTH-1:0]         out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [GW-1:0]            grant_id;
   logic [CW-1:0]            fifo_count;
`ifdef RR_MERGE_STATS_EN
   logic [NUM_IN*16-1:0]     grant_cnt;
`endif

   logic [WIDTH-1:0] din [NUM_IN];
   logic [WIDTH-1:0] mq [$];
   logic [WIDTH-1:0] mlast;
   int               mptr;
   int               last_grant;
   int               checks = 0;
   int               errors = 0;
   int               sent;

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         in_data[i*WIDTH +: WIDTH] = din[i];
      end
   end

   rr_router_merge #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .grant_id   (grant_id),
      .fifo_count (fifo_count)
`ifdef RR_MERGE_STATS_EN
      ,
      .grant_cnt  (grant_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: compare DUT against the model mid low phase, advance the
   // model as the coming edge should, then step to the next falling edge.
   task automatic tick();
      logic [NUM_IN-1:0] er;
      int g;
      int idx;
      #1;
      er = '0;
      g  = -1;
      if (!rst && mq.size() < DEPTH) begin
         for (int k = 0; k < NUM_IN; k++) begin
            idx = (mptr + k) % NUM_IN;
            if (g < 0 && in_valid[idx]) g = idx;
         end
      end
      if (g >= 0) er[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(er));
      check("grant_id", 64'(grant_id), 64'((g < 0) ? 0 : g));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("fifo_count", 64'(fifo_count), 64'(mq.size()));
      if (mq.size() != 0) check("out_data", 64'(out_data), 64'(mq[0]));
      else                check("out_data_hold", 64'(out_data), 64'(mlast));
      last_grant = g;
      if (rst) begin
         mq.delete();
         mptr  = 0;
         mlast = '0;
      end else begin
         if (mq.size() != 0 && out_ready) mlast = mq.pop_front();
         if (g >= 0) begin
            mq.push_back(din[g]);
            mptr = (g + 1) % NUM_IN;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [WIDTH-1:0] rnd_flit();
      return WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      for (int i = 0; i < NUM_IN; i++) din[i] = rnd_flit();
      mptr  = 0;
      mlast = '0;
      @(negedge clk);

      // Reset held with all inputs requesting.
      in_valid = 5'b11111;
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         check("rst_in_ready", 64'(in_ready), 64'(0));
         check("rst_fifo_count", 64'(fifo_count), 64'(0));
      end

      // Single flit on input 2.
      rst       = 1'b0;
      in_valid  = 5'b00100;
      din[2]    = 11'h5A3;
      out_ready = 1'b1;
      #1;
      check("single_in_ready", 64'(in_ready), 64'(5'b00100));
      tick();
      in_valid = '0;
      #1;
      check("single_out_valid", 64'(out_valid), 64'(1));
      check("single_out_data", 64'(out_data), 64'(11'h5A3));
      tick();
      tick();
      check("single_drained", 64'(fifo_count), 64'(0));

      // Fresh pointer, then all inputs valid for 10 cycles.
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 5'b11111;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("rr_grant_seq", 64'(grant_id), 64'(k % NUM_IN));
         tick();
         if (last_grant >= 0) din[last_grant] = rnd_flit();
      end
      in_valid = '0;
      for (int k = 0; k < 3; k++) tick();

      // Input 1 streams 6 flits into a stalled output.
      out_ready = 1'b0;
      sent      = 0;
      for (int k = 0; k < 6; k++) begin
         in_valid = (sent < 6) ? 5'b00010 : 5'b00000;
         tick();
         if (last_grant == 1) begin
            sent++;
            din[1] = rnd_flit();
         end
      end
      #1;
      check("stall_full_count", 64'(fifo_count), 64'(DEPTH));
      check("stall_in_ready", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      for (int k = 0; k < 14 && (sent < 6 || mq.size() != 0); k++) begin
         in_valid = (sent < 6) ? 5'b00010 : 5'b00000;
         tick();
         if (last_grant == 1) begin
            sent++;
            din[1] = rnd_flit();
         end
      end
      in_valid = '0;
      #1;
      check("stall_drained", 64'(fifo_count), 64'(0));

      // Full FIFO: pop only, then input 3 accepted.
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      out_ready = 1'b0;
      in_valid  = 5'b01000;
      for (int k = 0; k < DEPTH; k++) begin
         tick();
         if (last_grant == 3) din[3] = rnd_flit();
      end
      out_ready = 1'b1;
      #1;
      check("full_no_grant", 64'(in_ready), 64'(0));
      check("full_count", 64'(fifo_count), 64'(DEPTH));
      tick();
      #1;
      check("after_pop_count", 64'(fifo_count), 64'(DEPTH - 1));
      check("after_pop_ready", 64'(in_ready), 64'(5'b01000));
      tick();
      if (last_grant == 3) din[3] = rnd_flit();
      #1;
      check("push_pop_count", 64'(fifo_count), 64'(DEPTH - 1));

      // Reset with three flits buffered.
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = '0;
      #1;
      check("flush_out_valid", 64'(out_valid), 64'(0));
      check("flush_count", 64'(fifo_count), 64'(0));
      tick();
      tick();

`ifdef RR_MERGE_STATS_EN
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      in_valid  = 5'b00001;
      out_ready = 1'b1;
      repeat (70000) @(negedge clk);
      #1;
      check("grant_cnt_sat", 64'(grant_cnt[15:0]), 64'(16'hFFFF));
      check("grant_cnt_in1", 64'(grant_cnt[31:16]), 64'(0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
